deser_frame_align: RTL and testbench

Multi-channel word-alignment controller for the 1:DESERF ISERDES lanes. It runs in the divided global clock domain and watches the deserialized frame-clock word of each channel. It pulses BITSLIP per channel until the word equals the expected frame pattern, then qualifies and monitors lock. It replaces hand-tuned fixed alignment and generalises to NCH channels, any DESERF, and automatic re-alignment on loss of lock.

---
 rtl/deser_align_pkg.sv | 25 ++
 rtl/deser_align_ch.sv | 189 ++++++++++++++++++
 rtl/deser_frame_align.sv | 78 +++++++
 tb/tb_deser_frame_align.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/deser_align_pkg.sv
// deser_align_pkg: shared definitions for the deserializer word-alignment
// controller.
//   state_e          - per-channel alignment FSM states
//   DEFAULT_PATTERN  - default expected frame word (8 bits, truncated to DESERF)
//   cnt_w()          - width needed for a counter that must hold 0..limit
package deser_align_pkg;

  typedef enum logic [2:0] {
    ST_CHECK  = 3'd0,
    ST_SLIP   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;

  // Counters only ever count up to their limit and are compared for
  // equality, so limit+1 distinct values are enough.
  function automatic int cnt_w(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/deser_align_ch.sv
// deser_align_ch: word-alignment FSM and counters for one ISERDES lane.
// Optional feature macro: DESER_ALIGN_STATS_EN (adds slip/loss statistics).
// Ports:
//   clk_i        divided global clock
//   rst_i        asynchronous active-high reset
//   start_i      synchronous restart, overrides every state
//   word_i       deserialized frame-clock word of this lane
//   bitslip_o    one-cycle bitslip request to the ISERDES
//   locked_o     lane aligned and qualified
//   fail_o       slip budget exhausted (sticky until start/reset)
//   sliptotal_o  (stats build) saturating count of bitslip pulses
//   losscnt_o    (stats build) saturating count of lock-loss events
module deser_align_ch
  import deser_align_pkg::*;
#(
  parameter int                DESERF  = 8,
  parameter logic [DESERF-1:0] PATTERN = DEFAULT_PATTERN[DESERF-1:0],
  parameter int                SETTLE  = 4,
  parameter int                LOCKN   = 16,
  parameter int                LOSSN   = 4,
  parameter int                MAXSLIP = DESERF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DESERF-1:0] word_i,
  output logic              bitslip_o,
  output logic              locked_o,
  output logic              fail_o
`ifdef DESER_ALIGN_STATS_EN
  ,
  output logic [7:0]        sliptotal_o,
  output logic [7:0]        losscnt_o
`endif
);

  localparam int SW = cnt_w(MAXSLIP);
  localparam int MW = cnt_w(LOCKN);
  localparam int LW = cnt_w(LOSSN);
  localparam int WW = cnt_w(SETTLE);

  state_e        state_q, state_d;
  logic [SW-1:0] slipcnt_q, slipcnt_d;
  logic [MW-1:0] matchcnt_q, matchcnt_d;
  logic [LW-1:0] losscnt_q, losscnt_d;
  logic [WW-1:0] waitcnt_q, waitcnt_d;
  logic          bitslip_q, locked_q, fail_q;
  logic          match;
  logic          loss_event;

  assign match = (word_i == PATTERN);

  always_comb begin
    state_d    = state_q;
    slipcnt_d  = slipcnt_q;
    matchcnt_d = matchcnt_q;
    losscnt_d  = losscnt_q;
    waitcnt_d  = waitcnt_q;
    loss_event = 1'b0;
    if (start_i) begin
      state_d    = ST_CHECK;
      slipcnt_d  = '0;
      matchcnt_d = '0;
      losscnt_d  = '0;
      waitcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_CHECK: begin
          if (match) begin
            state_d    = ST_VERIFY;
            matchcnt_d = MW'(1);
          end else if (slipcnt_q == SW'(MAXSLIP)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SLIP;
          end
        end
        ST_SLIP: begin
          // slipcnt < MAXSLIP is guaranteed here, so this never wraps.
          slipcnt_d = slipcnt_q + SW'(1);
          waitcnt_d = '0;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          // FRAME is ignored while the ISERDES output settles.
          if (waitcnt_q == WW'(SETTLE - 1)) begin
            waitcnt_d = '0;
            state_d   = ST_CHECK;
          end else begin
            waitcnt_d = waitcnt_q + WW'(1);
          end
        end
        ST_VERIFY: begin
          if (match) begin
            matchcnt_d = matchcnt_q + MW'(1);
            if (matchcnt_q == MW'(LOCKN - 1)) begin
              state_d   = ST_LOCKED;
              losscnt_d = '0;
            end
          end else begin
            // Keep slipcnt so a flaky lane cannot slip forever.
            matchcnt_d = '0;
            state_d    = ST_CHECK;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            losscnt_d = '0;
          end else if (losscnt_q == LW'(LOSSN - 1)) begin
            // Lock lost: start a fresh alignment attempt.
            state_d    = ST_CHECK;
            slipcnt_d  = '0;
            matchcnt_d = '0;
            losscnt_d  = '0;
            loss_event = 1'b1;
          end else begin
            losscnt_d = losscnt_q + LW'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_CHECK;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_CHECK;
      slipcnt_q  <= '0;
      matchcnt_q <= '0;
      losscnt_q  <= '0;
      waitcnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slipcnt_q  <= slipcnt_d;
      matchcnt_q <= matchcnt_d;
      losscnt_q  <= losscnt_d;
      waitcnt_q  <= waitcnt_d;
    end
  end

  // Outputs are registered decodes of the current state, so each one trails
  // the state by a cycle; start clears them on the same edge as the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      bitslip_q <= !start_i && (state_q == ST_SLIP);
      locked_q  <= !start_i && (state_q == ST_LOCKED);
      fail_q    <= !start_i && (state_q == ST_FAIL);
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign fail_o    = fail_q;

`ifdef DESER_ALIGN_STATS_EN
  logic [7:0] sliptotal_q, lossevt_q;

  // Statistics survive start; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sliptotal_q <= '0;
      lossevt_q   <= '0;
    end else begin
      if (!start_i && (state_q == ST_SLIP) && (sliptotal_q != 8'hFF)) begin
        sliptotal_q <= sliptotal_q + 8'd1;
      end
      if (loss_event && (lossevt_q != 8'hFF)) begin
        lossevt_q <= lossevt_q + 8'd1;
      end
    end
  end

  assign sliptotal_o = sliptotal_q;
  assign losscnt_o   = lossevt_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
`endif

endmodule

// File: rtl/deser_frame_align.sv
// deser_frame_align: multi-channel ISERDES word-alignment controller.
// Each channel pulses BITSLIP until its frame word equals PATTERN, then
// qualifies and monitors lock, realigning automatically on loss.
// Optional feature macro: DESER_ALIGN_STATS_EN (adds SLIPTOTAL / LOSSCNT).
// Ports:
//   GCLK       divided global clock
//   RESET      asynchronous active-high reset
//   FRAME      deserialized frame words, channel k at [k*DESERF +: DESERF]
//   START      synchronous restart of all channels
//   BITSLIP    per-channel one-cycle bitslip pulse
//   LOCKED     per-channel aligned and qualified
//   FAIL       per-channel slip budget exhausted (sticky)
//   ALLLOCKED  registered AND of LOCKED
//   SLIPTOTAL  (stats build) per-channel 8-bit saturating bitslip count
//   LOSSCNT    (stats build) per-channel 8-bit saturating loss-event count
module deser_frame_align
  import deser_align_pkg::*;
#(
  parameter int                NCH     = 4,
  parameter int                DESERF  = 8,
  parameter logic [DESERF-1:0] PATTERN = DEFAULT_PATTERN[DESERF-1:0],
  parameter int                SETTLE  = 4,
  parameter int                LOCKN   = 16,
  parameter int                LOSSN   = 4,
  parameter int                MAXSLIP = DESERF
) (
  input  logic                  GCLK,
  input  logic                  RESET,
  input  logic [NCH*DESERF-1:0] FRAME,
  input  logic                  START,
  output logic [NCH-1:0]        BITSLIP,
  output logic [NCH-1:0]        LOCKED,
  output logic [NCH-1:0]        FAIL,
  output logic                  ALLLOCKED
`ifdef DESER_ALIGN_STATS_EN
  ,
  output logic [NCH*8-1:0]      SLIPTOTAL,
  output logic [NCH*8-1:0]      LOSSCNT
`endif
);

  logic alllocked_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    deser_align_ch #(
      .DESERF (DESERF),
      .PATTERN(PATTERN),
      .SETTLE (SETTLE),
      .LOCKN  (LOCKN),
      .LOSSN  (LOSSN),
      .MAXSLIP(MAXSLIP)
    ) u_ch (
      .clk_i      (GCLK),
      .rst_i      (RESET),
      .start_i    (START),
      .word_i     (FRAME[k*DESERF +: DESERF]),
      .bitslip_o  (BITSLIP[k]),
      .locked_o   (LOCKED[k]),
      .fail_o     (FAIL[k])
`ifdef DESER_ALIGN_STATS_EN
      ,
      .sliptotal_o(SLIPTOTAL[k*8 +: 8]),
      .losscnt_o  (LOSSCNT[k*8 +: 8])
`endif
    );
  end

  always_ff @(posedge GCLK or posedge RESET) begin
    if (RESET) begin
      alllocked_q <= 1'b0;
    end else begin
      alllocked_q <= &LOCKED;
    end
  end

  assign ALLLOCKED = alllocked_q;

endmodule

// File: tb/tb_deser_frame_align.sv
module tb_deser_frame_align;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic              GCLK = 1'b0;
  logic              RESET;
  logic              START;
  logic [NCH*DW-1:0] FRAME;
  logic [NCH-1:0]    BITSLIP, LOCKED, FAIL;
  logic              ALLLOCKED;
`ifdef DESER_ALIGN_STATS_EN
  logic [NCH*8-1:0]  SLIPTOTAL, LOSSCNT;
`endif

  always #5 GCLK = ~GCLK;

  deser_frame_align #(
    .NCH(NCH), .DESERF(DW), .PATTERN(8'hF0), .SETTLE(4),
    .LOCKN(16), .LOSSN(4), .MAXSLIP(8)
  ) dut (
    .GCLK     (GCLK),
    .RESET    (RESET),
    .FRAME    (FRAME),
    .START    (START),
    .BITSLIP  (BITSLIP),
    .LOCKED   (LOCKED),
    .FAIL     (FAIL),
    .ALLLOCKED(ALLLOCKED)
`ifdef DESER_ALIGN_STATS_EN
    ,
    .SLIPTOTAL(SLIPTOTAL),
    .LOSSCNT  (LOSSCNT)
`endif
  );

  // Lane model: frame word is PATTERN rotated right by rot[k]; each BITSLIP
  // rotates it left by one. frc[k] overrides the lane with a fixed word.
  int         rot    [NCH];
  logic       frc    [NCH];
  logic [7:0] fval   [NCH];
  int         pulses [NCH];
  int         cyc;
  int         checks;
  int         failures;

  typedef struct {
    int         cyc;
    logic [3:0] bs;
    logic [3:0] lk;
    logic [3:0] fl;
    logic       al;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [7:0] ror8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_frame();
    for (int k = 0; k < NCH; k++)
      FRAME[k*DW +: DW] = frc[k] ? fval[k] : ror8(8'hF0, rot[k]);
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge GCLK);
    #1;
    cyc++;
    for (int k = 0; k < NCH; k++) begin
      if (BITSLIP[k]) begin
        pulses[k]++;
        rot[k] = (rot[k] + 7) % 8;
      end
    end
    drive_frame();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    START = 1'b0;
    for (int k = 0; k < NCH; k++) pulses[k] = 0;
    drive_frame();
    #1;
    chk("rst_bitslip", {28'd0, BITSLIP}, 32'd0);
    chk("rst_locked", {28'd0, LOCKED}, 32'd0);
    chk("rst_fail", {28'd0, FAIL}, 32'd0);
    chk("rst_alllocked", {31'd0, ALLLOCKED}, 32'd0);
    repeat (2) @(posedge GCLK);
    @(negedge GCLK);
    RESET = 1'b0;
    cyc = -1;
  endtask

  int p0;
  int s;

  initial begin
    checks   = 0;
    failures = 0;
    FRAME    = '0;
    for (int k = 0; k < NCH; k++) begin
      rot[k] = 0; frc[k] = 1'b0; fval[k] = 8'h00; pulses[k] = 0;
    end

    // ---- A: pattern present on all channels from reset release ----
    do_reset();
    while (cyc < 15) tick();
    chk("A_locked15", {28'd0, LOCKED}, 32'h0);
    tick();
    chk("A_locked16", {28'd0, LOCKED}, 32'hF);
    chk("A_all16", {31'd0, ALLLOCKED}, 32'd0);
    tick();
    chk("A_all17", {31'd0, ALLLOCKED}, 32'd1);
    chk("A_noslip", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
`ifdef DESER_ALIGN_STATS_EN
    chk("A_sliptotal", SLIPTOTAL, 32'd0);
`endif

    // ---- B: ch1 rotated by 3, ch2 stuck at AA, ch0/ch3 aligned ----
    rot[1] = 3; frc[2] = 1'b1; fval[2] = 8'hAA;
    do_reset();
    tbl[0]  = '{0,  4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1,  4'b0110, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{2,  4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{6,  4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{7,  4'b0110, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{13, 4'b0110, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{15, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{16, 4'b0000, 4'b1001, 4'b0000, 1'b0};
    tbl[8]  = '{19, 4'b0100, 4'b1001, 4'b0000, 1'b0};
    tbl[9]  = '{33, 4'b0000, 4'b1001, 4'b0000, 1'b0};
    tbl[10] = '{34, 4'b0000, 4'b1011, 4'b0000, 1'b0};
    tbl[11] = '{43, 4'b0100, 4'b1011, 4'b0000, 1'b0};
    tbl[12] = '{48, 4'b0000, 4'b1011, 4'b0000, 1'b0};
    tbl[13] = '{49, 4'b0000, 4'b1011, 4'b0100, 1'b0};
    for (int i = 0; i < 14; i++) begin
      while (cyc < tbl[i].cyc) tick();
      chk($sformatf("B%0d_bitslip", i), {28'd0, BITSLIP}, {28'd0, tbl[i].bs});
      chk($sformatf("B%0d_locked", i), {28'd0, LOCKED}, {28'd0, tbl[i].lk});
      chk($sformatf("B%0d_fail", i), {28'd0, FAIL}, {28'd0, tbl[i].fl});
      chk($sformatf("B%0d_all", i), {31'd0, ALLLOCKED}, {31'd0, tbl[i].al});
    end
    while (cyc < 60) tick();
    chk("B_pulses0", pulses[0], 0);
    chk("B_pulses1", pulses[1], 3);
    chk("B_pulses2", pulses[2], 8);
    chk("B_pulses3", pulses[3], 0);
    chk("B_fail60", {28'd0, FAIL}, 32'h4);
`ifdef DESER_ALIGN_STATS_EN
    chk("B_sliptotal1", SLIPTOTAL[15:8], 3);
    chk("B_sliptotal2", SLIPTOTAL[23:16], 8);
`endif

    // ---- Loss of lock on ch1: 3 bad, 1 good, 4 bad ----
    frc[1] = 1'b1; fval[1] = 8'h00; drive_frame();
    repeat (3) tick();
    chk("L_burst1", {31'd0, LOCKED[1]}, 32'd1);
    frc[1] = 1'b0; drive_frame();
    tick();
    frc[1] = 1'b1; drive_frame();
    repeat (3) tick();
    chk("L_burst2_3", {31'd0, LOCKED[1]}, 32'd1);
    tick();
    tick();
    chk("L_dropped", {31'd0, LOCKED[1]}, 32'd0);
    p0 = pulses[1];
    while (cyc < 125) begin
      tick();
      if (cyc == 70) chk("L_reslip70", {31'd0, BITSLIP[1]}, 32'd1);
    end
    chk("L_reslips", pulses[1] - p0, 8);
    chk("L_fail1", {28'd0, FAIL}, 32'h6);
`ifdef DESER_ALIGN_STATS_EN
    chk("L_losscnt1", LOSSCNT[15:8], 1);
    chk("L_sliptotal1", SLIPTOTAL[15:8], 11);
`endif

    // ---- START restarts all channels and clears FAIL ----
    frc[1] = 1'b0; rot[1] = 0; drive_frame();
    START = 1'b1;
    tick();
    START = 1'b0;
    s = cyc;
    chk("S_fail", {28'd0, FAIL}, 32'h0);
    chk("S_locked", {28'd0, LOCKED}, 32'h0);
    chk("S_bitslip", {28'd0, BITSLIP}, 32'h0);
    tick();
    chk("S_bitslip1", {28'd0, BITSLIP}, 32'h0);
    tick();
    chk("S_bitslip2", {28'd0, BITSLIP}, 32'h4);
    while (cyc < s + 17) tick();
    chk("S_relock", {28'd0, LOCKED}, 32'hB);
`ifdef DESER_ALIGN_STATS_EN
    chk("S_losscnt1_kept", LOSSCNT[15:8], 1);
    chk("S_sliptotal1_kept", SLIPTOTAL[15:8], 11);
`endif
    while (cyc < s + 20) tick();
    chk("S_bitslip20", {28'd0, BITSLIP}, 32'h4);

    // ---- RESET during a BITSLIP cycle clears outputs at once ----
    RESET = 1'b1;
    #1;
    chk("R_bitslip", {28'd0, BITSLIP}, 32'h0);
    chk("R_locked", {28'd0, LOCKED}, 32'h0);
    chk("R_fail", {28'd0, FAIL}, 32'h0);
    for (int k = 0; k < NCH; k++) begin rot[k] = 0; frc[k] = 1'b0; end
    do_reset();
    while (cyc < 15) tick();
    chk("R_locked15", {28'd0, LOCKED}, 32'h0);
    tick();
    chk("R_locked16", {28'd0, LOCKED}, 32'hF);
    chk("R_noslip", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
`ifdef DESER_ALIGN_STATS_EN
    chk("R_stats_cleared", {SLIPTOTAL, LOSSCNT}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
